// File: rtl/axis_dot_mac.sv
// rtl/axis_dot_mac.sv - streaming dot-product MAC with bias, ReLU and saturation
module axis_dot_mac #(
  parameter int DATAWIDTH = 32,
  parameter int ACCWIDTH  = 40,
  parameter int MAXLEN    = 8,
  parameter bit RELU      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_start,
  output logic                 ex_startAck,
  input  logic [ACCWIDTH-1:0]  bias,
  input  logic [DATAWIDTH-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 err_len
);

  localparam int HW = DATAWIDTH / 2;
  localparam int CW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXLEN - 1);
  localparam logic signed [ACCWIDTH-1:0] SAT_MAX =
    {{(ACCWIDTH-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [ACCWIDTH-1:0] SAT_MIN =
    {{(ACCWIDTH-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, START, ACC, OUT} state_t;

  state_t                       state, state_nx;
  logic signed [ACCWIDTH-1:0]   acc;
  logic        [CW-1:0]         cnt;
  logic                         hit_max;
  logic signed [HW-1:0]         w_op, p_op;
  logic signed [DATAWIDTH-1:0]  w_x, p_x, prod;
  logic signed [ACCWIDTH-1:0]   prod_x;
  logic signed [ACCWIDTH-1:0]   relu_val;
  logic        [DATAWIDTH-1:0]  sat_val;

  // Operands are sign-extended to the full product width so the product is exact.
  assign w_op    = s_data[DATAWIDTH-1:HW];
  assign p_op    = s_data[HW-1:0];
  assign w_x     = DATAWIDTH'(w_op);
  assign p_x     = DATAWIDTH'(p_op);
  assign prod    = w_x * p_x;
  assign prod_x  = ACCWIDTH'(prod);
  assign hit_max = (cnt == CNT_LAST);

  // State register; reset drops the partial frame and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_nx    = state;
    ex_startAck = 1'b0;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    case (state)
      IDLE: begin
        if (ex_start) state_nx = START;
      end
      START: begin
        ex_startAck = 1'b1;
        if (!ex_start) state_nx = ACC;
      end
      ACC: begin
        s_ready = 1'b1;
        if (s_valid && (s_last || hit_max)) state_nx = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator, beat counter and sticky length error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      err_len <= 1'b0;
    end else begin
      case (state)
        IDLE: cnt <= '0;
        START: begin
          acc     <= bias;
          cnt     <= '0;
          err_len <= 1'b0;
        end
        ACC: begin
          if (s_valid) begin
            acc <= acc + prod_x;
            cnt <= cnt + 1'b1;
            if (hit_max && !s_last) err_len <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign relu_val = (RELU && acc[ACCWIDTH-1]) ? '0 : acc;

  // Clamp the (optionally rectified) accumulator into the output word range.
  always_comb begin
    sat_val = relu_val[DATAWIDTH-1:0];
    if (relu_val > SAT_MAX)      sat_val = SAT_MAX[DATAWIDTH-1:0];
    else if (relu_val < SAT_MIN) sat_val = SAT_MIN[DATAWIDTH-1:0];
  end

  assign m_data = m_valid ? sat_val : '0;
  assign m_last = m_valid;

endmodule
